// File: rtl/led_pkg.sv
// Shared types and constants for the LED driver: sequencer state encoding,
// index-width helper, and the default LED vector width used by pattern generators.
package led_pkg;

  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } led_seq_state_t;

  localparam int LED_W_DEFAULT = 18;

  // Index width that never collapses to zero bits for a single-entry set
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_mode_timer.sv
// Up-counter with synchronous clear/enable and a terminal-count flag; used for
// both the blanking countdown and the auto-cycle dwell count.
module led_mode_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count register: clear has priority over enable
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/led_mode_sequencer.sv
// Registered LED pattern selector: picks one of NUM_MODES patterns, switching on
// load / next / auto-dwell requests with an optional all-off blanking window.
module led_mode_sequencer
  import led_pkg::*;
#(
  parameter int NUM_MODES    = 4,
  parameter int LED_W        = LED_W_DEFAULT,
  parameter int BLANK_CYCLES = 4,
  parameter int DWELL_CYCLES = 1024,
  localparam int MODE_W      = clog2_min1(NUM_MODES)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_MODES*LED_W-1:0] i_mode_bus,
  input  logic                       i_load_en,
  input  logic [MODE_W-1:0]          i_load_mode,
  input  logic                       i_next_pulse,
  input  logic                       i_auto_en,
  output logic [LED_W-1:0]           o_led_out,
  output logic [MODE_W-1:0]          o_mode_cur,
  output logic                       o_switching
);

  localparam int TMAX = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]     BLANK_TERM = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : {TW{1'b0}};
  localparam logic [TW-1:0]     DWELL_TERM = TW'(DWELL_CYCLES - 1);
  localparam logic [MODE_W-1:0] LAST_MODE  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W:0]   MODE_LIMIT = (MODE_W + 1)'(NUM_MODES);

  led_seq_state_t    r_state;
  logic [MODE_W-1:0] r_mode;
  logic [LED_W-1:0]  r_led;
  logic              r_switching;

  logic              w_show;
  logic              w_load_ok;
  logic [MODE_W-1:0] w_next_mode;
  logic              w_accept;
  logic [MODE_W-1:0] w_target;
  logic              w_dwell_en;
  logic              w_dwell_clr;
  logic              w_dwell_tc;
  logic              w_expiry;
  logic              w_blank_tc;
  logic [LED_W-1:0]  w_pat_cur;
  logic [LED_W-1:0]  w_pat_target;

  assign w_show      = (r_state == SHOW);
  assign w_load_ok   = ({1'b0, i_load_mode} < MODE_LIMIT) && (i_load_mode != r_mode);
  // Explicit wrap keeps non-power-of-2 mode counts inside the pattern bus
  assign w_next_mode = (r_mode == LAST_MODE) ? {MODE_W{1'b0}} : r_mode + MODE_W'(1);
  assign w_dwell_en  = w_show & i_auto_en;
  assign w_expiry    = w_dwell_en & w_dwell_tc;
  assign w_dwell_clr = ~w_dwell_en | w_expiry | w_accept;

  assign w_pat_cur    = i_mode_bus[int'(r_mode) * LED_W +: LED_W];
  assign w_pat_target = i_mode_bus[int'(w_target) * LED_W +: LED_W];

  // Request arbiter: a present but invalid load still blocks next and auto
  always_comb begin
    w_accept = 1'b0;
    w_target = r_mode;
    if (w_show) begin
      if (i_load_en) begin
        if (w_load_ok) begin
          w_accept = 1'b1;
          w_target = i_load_mode;
        end else begin
          w_accept = 1'b0;
        end
      end else if (i_next_pulse || w_expiry) begin
        w_accept = 1'b1;
        w_target = w_next_mode;
      end else begin
        w_accept = 1'b0;
      end
    end else begin
      w_accept = 1'b0;
    end
  end

  led_mode_timer #(.W(TW)) u_blank_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_show),
    .i_en    (~w_show),
    .i_term  (BLANK_TERM),
    .o_tc    (w_blank_tc)
  );

  led_mode_timer #(.W(TW)) u_dwell_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_dwell_clr),
    .i_en    (w_dwell_en),
    .i_term  (DWELL_TERM),
    .o_tc    (w_dwell_tc)
  );

  // Sequencer FSM with registered LED, mode and switching outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= SHOW;
      r_mode      <= {MODE_W{1'b0}};
      r_led       <= {LED_W{1'b0}};
      r_switching <= 1'b0;
    end else begin
      case (r_state)
        SHOW: begin
          if (w_accept) begin
            r_mode <= w_target;
            if (BLANK_CYCLES > 0) begin
              r_state     <= BLANK;
              r_led       <= {LED_W{1'b0}};
              r_switching <= 1'b1;
            end else begin
              r_led       <= w_pat_target;
              r_switching <= 1'b0;
            end
          end else begin
            r_led       <= w_pat_cur;
            r_switching <= 1'b0;
          end
        end
        BLANK: begin
          if (w_blank_tc) begin
            r_state     <= SHOW;
            r_led       <= w_pat_cur;
            r_switching <= 1'b0;
          end else begin
            r_led       <= {LED_W{1'b0}};
            r_switching <= 1'b1;
          end
        end
        default: begin
          r_state     <= SHOW;
          r_led       <= {LED_W{1'b0}};
          r_switching <= 1'b0;
        end
      endcase
    end
  end

  assign o_led_out   = r_led;
  assign o_mode_cur  = r_mode;
  assign o_switching = r_switching;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench: a 4-mode/4-blank sequencer and a 5-mode/no-blank sequencer,
// both with an 8-cycle dwell, driven from vector tables plus auto-cycle sequences.
module tb_led_mode_sequencer;

  localparam int LW = 18;

  typedef struct {
    logic          rst;
    logic          ld;
    logic [2:0]    lm;
    logic          nx;
    logic          au;
    logic [LW-1:0] led;
    logic [2:0]    mode;
    logic          sw;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, ld_a, nx_a, au_a, sw_a;
  logic [1:0]      lm_a, mode_a;
  logic [4*LW-1:0] bus_a;
  logic [LW-1:0]   led_a;

  logic            rst_b, ld_b, nx_b, au_b, sw_b;
  logic [2:0]      lm_b, mode_b;
  logic [5*LW-1:0] bus_b;
  logic [LW-1:0]   led_b;

  int checks = 0;
  int errors = 0;
  vec_t qa[$];
  vec_t qb[$];

  led_mode_sequencer #(.NUM_MODES(4), .LED_W(LW), .BLANK_CYCLES(4), .DWELL_CYCLES(8)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_mode_bus(bus_a), .i_load_en(ld_a), .i_load_mode(lm_a),
    .i_next_pulse(nx_a), .i_auto_en(au_a), .o_led_out(led_a), .o_mode_cur(mode_a), .o_switching(sw_a)
  );

  led_mode_sequencer #(.NUM_MODES(5), .LED_W(LW), .BLANK_CYCLES(0), .DWELL_CYCLES(8)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_mode_bus(bus_b), .i_load_en(ld_b), .i_load_mode(lm_b),
    .i_next_pulse(nx_b), .i_auto_en(au_b), .o_led_out(led_b), .o_mode_cur(mode_b), .o_switching(sw_b)
  );

  task automatic add(input bit to_b, input int n, input logic rst, input logic ld, input logic [2:0] lm,
                     input logic nx, input logic au, input logic [LW-1:0] led, input logic [2:0] mode,
                     input logic sw);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lm = lm; v.nx = nx; v.au = au;
    v.led = led; v.mode = mode; v.sw = sw;
    for (int i = 0; i < n; i++) begin
      if (to_b) qb.push_back(v);
      else qa.push_back(v);
    end
  endtask

  task automatic chk(input string name, input logic [LW-1:0] al, input logic [LW-1:0] el,
                     input logic [2:0] am, input logic [2:0] em, input logic as, input logic es);
    checks++;
    if (al !== el || am !== em || as !== es) begin
      errors++;
      $display("FAIL %s: got led=%h mode=%0d sw=%0b, expected led=%h mode=%0d sw=%0b",
               name, al, am, as, el, em, es);
    end
  endtask

  task automatic step_a(input logic rst, input logic ld, input logic [1:0] lm, input logic nx, input logic au);
    @(negedge clk);
    rst_a = rst; ld_a = ld; lm_a = lm; nx_a = nx; au_a = au;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic rst, input logic ld, input logic [2:0] lm, input logic nx, input logic au);
    @(negedge clk);
    rst_b = rst; ld_b = ld; lm_b = lm; nx_b = nx; au_b = au;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] em;
    rst_a = 1'b1; ld_a = 1'b0; lm_a = 2'd0; nx_a = 1'b0; au_a = 1'b0;
    rst_b = 1'b1; ld_b = 1'b0; lm_b = 3'd0; nx_b = 1'b0; au_b = 1'b0;
    for (int k = 0; k < 4; k++) bus_a[k*LW +: LW] = 18'h1 << k;
    for (int k = 0; k < 5; k++) bus_b[k*LW +: LW] = 18'h1 << k;

    // table A: reset, next steps with 4-cycle blank, wrap, load priority, drops, reset in blank
    add(0, 2, 1, 0, 0, 0, 0, 18'h0, 0, 0);
    add(0, 2, 0, 0, 0, 0, 0, 18'h1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 18'h0, 1, 1);
    add(0, 3, 0, 0, 0, 0, 0, 18'h0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 18'h2, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0, 18'h0, 2, 1);
    add(0, 3, 0, 0, 0, 0, 0, 18'h0, 2, 1);
    add(0, 1, 0, 0, 0, 0, 0, 18'h4, 2, 0);
    add(0, 1, 0, 0, 0, 1, 0, 18'h0, 3, 1);
    add(0, 3, 0, 0, 0, 0, 0, 18'h0, 3, 1);
    add(0, 1, 0, 0, 0, 0, 0, 18'h8, 3, 0);
    add(0, 1, 0, 0, 0, 1, 0, 18'h0, 0, 1);
    add(0, 3, 0, 0, 0, 0, 0, 18'h0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 18'h1, 0, 0);
    add(0, 1, 0, 1, 2, 1, 0, 18'h0, 2, 1);
    add(0, 3, 0, 0, 0, 0, 0, 18'h0, 2, 1);
    add(0, 1, 0, 0, 0, 0, 0, 18'h4, 2, 0);
    add(0, 1, 0, 1, 2, 0, 0, 18'h4, 2, 0);
    add(0, 1, 0, 1, 2, 1, 0, 18'h4, 2, 0);
    add(0, 1, 0, 0, 0, 1, 0, 18'h0, 3, 1);
    add(0, 1, 0, 0, 0, 1, 0, 18'h0, 3, 1);
    add(0, 1, 0, 1, 0, 0, 0, 18'h0, 3, 1);
    add(0, 1, 0, 0, 0, 0, 0, 18'h0, 3, 1);
    add(0, 2, 0, 0, 0, 0, 0, 18'h8, 3, 0);
    add(0, 1, 0, 1, 1, 0, 0, 18'h0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 0, 18'h0, 0, 0);
    add(0, 2, 0, 0, 0, 0, 0, 18'h1, 0, 0);

    // table B: 5 modes, no blank, explicit wrap, out-of-range loads dropped
    add(1, 2, 1, 0, 0, 0, 0, 18'h0,  0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 18'h1,  0, 0);
    add(1, 1, 0, 1, 4, 0, 0, 18'h10, 4, 0);
    add(1, 1, 0, 0, 0, 0, 0, 18'h10, 4, 0);
    add(1, 1, 0, 0, 0, 1, 0, 18'h1,  0, 0);
    add(1, 1, 0, 1, 6, 0, 0, 18'h1,  0, 0);
    add(1, 1, 0, 1, 5, 0, 0, 18'h1,  0, 0);
    add(1, 1, 0, 1, 7, 1, 0, 18'h1,  0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 18'h2,  1, 0);
    add(1, 1, 0, 1, 0, 0, 0, 18'h1,  0, 0);

    foreach (qa[i]) begin
      step_a(qa[i].rst, qa[i].ld, qa[i].lm[1:0], qa[i].nx, qa[i].au);
      chk($sformatf("tblA[%0d]", i), led_a, qa[i].led, {1'b0, mode_a}, qa[i].mode, sw_a, qa[i].sw);
    end

    // pattern input change tracks one cycle later
    @(negedge clk);
    bus_a[0 +: LW] = 18'h3FFFF;
    step_a(0, 0, 0, 0, 0);
    chk("track_new", led_a, 18'h3FFFF, {1'b0, mode_a}, 3'd0, sw_a, 1'b0);
    @(negedge clk);
    bus_a[0 +: LW] = 18'h1;
    step_a(0, 0, 0, 0, 0);
    chk("track_back", led_a, 18'h1, {1'b0, mode_a}, 3'd0, sw_a, 1'b0);

    // auto-cycle: 8 SHOW cycles then 4 blank; one-cycle auto_en drop restarts the dwell
    for (int e = 1; e <= 23; e++) begin
      step_a(0, 0, 0, 0, (e == 15) ? 1'b0 : 1'b1);
      if (e < 8)       chk($sformatf("auto0_e%0d", e), led_a, 18'h1, {1'b0, mode_a}, 3'd0, sw_a, 1'b0);
      else if (e < 12) chk($sformatf("auto_blank_e%0d", e), led_a, 18'h0, {1'b0, mode_a}, 3'd1, sw_a, 1'b1);
      else if (e < 23) chk($sformatf("auto1_e%0d", e), led_a, 18'h2, {1'b0, mode_a}, 3'd1, sw_a, 1'b0);
      else             chk("auto_restart_e23", led_a, 18'h0, {1'b0, mode_a}, 3'd2, sw_a, 1'b1);
    end
    step_a(0, 0, 0, 0, 0);
    rst_a = 1'b1;

    foreach (qb[i]) begin
      step_b(qb[i].rst, qb[i].ld, qb[i].lm, qb[i].nx, qb[i].au);
      chk($sformatf("tblB[%0d]", i), led_b, qb[i].led, mode_b, qb[i].mode, sw_b, qb[i].sw);
    end

    // auto-cycle with no blank: mode 0 -> 4 -> 0 every 8 cycles
    step_b(0, 1, 3'd4, 0, 0);
    for (int e = 1; e <= 16; e++) begin
      step_b(0, 0, 0, 0, 1);
      em = (e < 8) ? 3'd4 : (e < 16) ? 3'd0 : 3'd1;
      chk($sformatf("autoB_e%0d", e), led_b, 18'h1 << em, mode_b, em, sw_b, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
